// File: rtl/alarm_pkg.sv
// alarm_pkg: shared BCD time layout and ringer state encoding.
//   bcd_time_t   : 20-bit packed BCD hh:mm:ss, hour tens in the MSBs
//   ring_state_t : IDLE / RING / SNOOZE
package alarm_pkg;
   localparam int TIME_W = 20;
   typedef struct packed {
      logic [1:0] h_t;
      logic [3:0] h_u;
      logic [2:0] m_t;
      logic [3:0] m_u;
      logic [2:0] s_t;
      logic [3:0] s_u;
   } bcd_time_t;
   typedef enum logic [1:0] {IDLE, RING, SNOOZE} ring_state_t;
endpackage

// File: rtl/bcd_add_minutes.sv
// bcd_add_minutes: adds a 0..9 minute increment to a BCD time of day, wrapping 23:59 -> 00:00.
//   t   : input time (bcd_time_t)
//   inc : minutes to add, single BCD digit
//   sum : resulting time; seconds are copied unchanged
module bcd_add_minutes
   import alarm_pkg::*;
(
   input  bcd_time_t  t,
   input  logic [3:0] inc,
   output bcd_time_t  sum
);
   logic [4:0] mu_sum;
   logic       c_mu;
   logic       c_mt;
   logic       wrap;
   always_comb begin
      mu_sum = {1'b0, t.m_u} + {1'b0, inc};
      c_mu   = mu_sum > 5'd9;
      c_mt   = c_mu && t.m_t == 3'd5;
      wrap   = t.h_t == 2'd2 && t.h_u == 4'd3;
      sum    = t;
      sum.m_u = c_mu ? 4'(mu_sum - 5'd10) : mu_sum[3:0];
      sum.m_t = c_mt ? 3'd0 : t.m_t + {2'b0, c_mu};
      sum.h_u = !c_mt ? t.h_u : (wrap || t.h_u == 4'd9) ? 4'd0 : t.h_u + 4'd1;
      sum.h_t = !c_mt ? t.h_t : wrap ? 2'd0 : t.h_t + {1'b0, t.h_u == 4'd9};
   end
endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer: rings the buzzer when the clock reaches the alarm time, with snooze, stop and auto-timeout.
//   clk, reset (async, active-low)
//   cur_time, alarm_time : BCD hh:mm:ss
//   alarm_en             : alarm armed (level)
//   sec_tick, snooze_btn, stop_btn : one-cycle pulses
//   ringing, buzzer, snooze_active, snooze_time : registered outputs
module alarm_ringer #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_MIN     = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] cur_time,
   input  logic [19:0] alarm_time,
   input  logic        alarm_en,
   input  logic        sec_tick,
   input  logic        snooze_btn,
   input  logic        stop_btn,
   output logic        ringing,
   output logic        buzzer,
   output logic        snooze_active,
   output logic [19:0] snooze_time
);
   import alarm_pkg::*;

   ring_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic        a_hit_q, a_hit_d;
   logic        s_hit_q, s_hit_d;
   logic [19:0] snooze_time_q, snooze_time_d;
   logic        ringing_q, ringing_d;
   logic        buzzer_q, buzzer_d;
   logic        snooze_q, snooze_d;
   logic        enter_ring;
   logic        ring_tick;
   bcd_time_t   snz_sum;

   bcd_add_minutes u_add (
      .t   (cur_time),
      .inc (4'(SNOOZE_MIN)),
      .sum (snz_sum)
   );

   always_comb begin
      a_hit_d       = cur_time == alarm_time;
      s_hit_d       = cur_time == snooze_time_q;
      ring_tick     = state_q == RING && sec_tick;
      state_d       = state_q;
      snooze_time_d = snooze_time_q;
      if (!alarm_en || stop_btn)
         state_d = IDLE;
      else if (state_q == RING && snooze_btn) begin
         state_d       = SNOOZE;
         snooze_time_d = snz_sum;
      end
      else if (ring_tick && cnt_q == 8'(RING_TIMEOUT_S - 1))
         state_d = IDLE;
      // only the rising edge of a match triggers, so a stop inside the matching second sticks
      else if ((state_q == IDLE && a_hit_d && !a_hit_q) || (state_q == SNOOZE && s_hit_d && !s_hit_q))
         state_d = RING;
      // a tick coinciding with RING entry is swallowed by the clear
      enter_ring = state_d == RING && state_q != RING;
      cnt_d      = enter_ring ? 8'd0 : ring_tick ? cnt_q + 8'd1 : cnt_q;
      phase_d    = enter_ring ? 1'b1 : ring_tick ? ~phase_q : phase_q;
      ringing_d  = state_d == RING;
      buzzer_d   = ringing_d & phase_d;
      snooze_d   = state_d == SNOOZE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         phase_q       <= 1'b0;
         a_hit_q       <= 1'b0;
         s_hit_q       <= 1'b0;
         snooze_time_q <= '0;
         ringing_q     <= 1'b0;
         buzzer_q      <= 1'b0;
         snooze_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         phase_q       <= phase_d;
         a_hit_q       <= a_hit_d;
         s_hit_q       <= s_hit_d;
         snooze_time_q <= snooze_time_d;
         ringing_q     <= ringing_d;
         buzzer_q      <= buzzer_d;
         snooze_q      <= snooze_d;
      end
   end

   assign ringing       = ringing_q;
   assign buzzer        = buzzer_q;
   assign snooze_active = snooze_q;
   assign snooze_time   = snooze_time_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: scoreboard bench for alarm_ringer against a seconds-of-day reference model.
module tb_alarm_ringer;
   localparam int TO  = 60;
   localparam int SNZ = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] cur_time;
   logic [19:0] alarm_time;
   logic        alarm_en;
   logic        sec_tick;
   logic        snooze_btn;
   logic        stop_btn;
   logic        ringing;
   logic        buzzer;
   logic        snooze_active;
   logic [19:0] snooze_time;

   always #5 clk = ~clk;

   alarm_ringer #(.RING_TIMEOUT_S(TO), .SNOOZE_MIN(SNZ)) dut (
      .clk           (clk),
      .reset         (reset),
      .cur_time      (cur_time),
      .alarm_time    (alarm_time),
      .alarm_en      (alarm_en),
      .sec_tick      (sec_tick),
      .snooze_btn    (snooze_btn),
      .stop_btn      (stop_btn),
      .ringing       (ringing),
      .buzzer        (buzzer),
      .snooze_active (snooze_active),
      .snooze_time   (snooze_time)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] sb[$];

   int          now;
   logic [19:0] alarm;
   bit          en;
   int          ms;
   int          mcnt;
   bit          mph, mah, msh;
   logic [19:0] msnz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int s);
      int h, m, sc;
      h  = s / 3600;
      m  = (s / 60) % 60;
      sc = s % 60;
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10)};
   endfunction

   function automatic logic [19:0] mk(input int h, input int m, input int s);
      return to_bcd(h * 3600 + m * 60 + s);
   endfunction

   function automatic int to_sec(input logic [19:0] t);
      return (int'(t[19:18]) * 10 + int'(t[17:14])) * 3600 +
             (int'(t[13:11]) * 10 + int'(t[10:7])) * 60 +
             int'(t[6:4]) * 10 + int'(t[3:0]);
   endfunction

   function automatic logic [31:0] outs();
      return {9'b0, ringing, buzzer, snooze_active, snooze_time};
   endfunction

   task automatic model_reset();
      ms = 0; mcnt = 0; mph = 0; mah = 0; msh = 0; msnz = '0;
   endtask

   task automatic step(input bit tk, input bit sz, input bit sp);
      bit ahit, shit;
      int nst;
      @(negedge clk);
      if (tk) now = (now + 1) % 86400;
      cur_time   = to_bcd(now);
      alarm_time = alarm;
      alarm_en   = en;
      sec_tick   = tk;
      snooze_btn = sz;
      stop_btn   = sp;
      ahit = to_bcd(now) == alarm;
      shit = to_bcd(now) == msnz;
      nst  = ms;
      if (!en || sp) nst = 0;
      else if (ms == 1 && sz) begin
         nst  = 2;
         msnz = to_bcd((to_sec(to_bcd(now)) + SNZ * 60) % 86400);
      end
      else if (ms == 1 && tk && mcnt + 1 == TO) nst = 0;
      else if ((ms == 0 && ahit && !mah) || (ms == 2 && shit && !msh)) nst = 1;
      if (nst == 1 && ms != 1) begin
         mcnt = 0;
         mph  = 1;
      end else if (ms == 1 && tk) begin
         mcnt++;
         mph = !mph;
      end
      mah = ahit;
      msh = shit;
      ms  = nst;
      sb.push_back({9'b0, nst == 1, nst == 1 && mph, nst == 2, msnz});
      @(posedge clk);
      #1;
      check("step", outs(), sb.pop_front());
      sec_tick   = 1'b0;
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
   endtask

   task automatic sec(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0);
         step(0, 0, 0);
         step(0, 0, 0);
      end
   endtask

   task automatic go(input int h, input int m, input int s);
      now = h * 3600 + m * 60 + s;
      step(0, 0, 0);
   endtask

   initial begin
      reset = 1'b0;
      en    = 1;
      alarm = mk(7, 30, 0);
      now   = 7 * 3600 + 29 * 60 + 58;
      cur_time = to_bcd(now); alarm_time = alarm; alarm_en = 1'b1;
      sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("reset_out", outs(), 32'h0);
      @(negedge clk) reset = 1'b1;

      sec(2);
      check("ring_on", {31'b0, ringing}, 32'd1);
      check("buzz_on", {31'b0, buzzer}, 32'd1);
      sec(1);
      check("buzz_toggle", {31'b0, buzzer}, 32'd0);
      sec(58);
      check("ring_tick59", {31'b0, ringing}, 32'd1);
      sec(1);
      check("timeout", {31'b0, ringing}, 32'd0);

      go(7, 29, 59);
      go(7, 30, 0);
      sec(4);
      step(0, 1, 0);
      check("snz_active", {31'b0, snooze_active}, 32'd1);
      check("snz_time", {12'b0, snooze_time}, {12'b0, mk(7, 35, 4)});
      check("snz_buzz", {31'b0, buzzer}, 32'd0);
      go(7, 35, 3);
      sec(1);
      check("rering", {31'b0, ringing}, 32'd1);
      sec(59);
      check("rering_59", {31'b0, ringing}, 32'd1);
      sec(1);
      check("rering_to", {31'b0, ringing}, 32'd0);

      alarm = mk(23, 58, 17);
      go(23, 58, 16);
      sec(1);
      step(0, 1, 0);
      check("wrap_day", {12'b0, snooze_time}, {12'b0, mk(0, 3, 17)});
      step(0, 0, 1);
      check("stop_snz", {31'b0, snooze_active}, 32'd0);
      alarm = mk(9, 59, 0);
      go(9, 58, 59);
      sec(1);
      step(0, 1, 0);
      check("wrap_hour", {12'b0, snooze_time}, {12'b0, mk(10, 4, 0)});
      step(0, 0, 1);

      go(9, 58, 59);
      go(9, 59, 0);
      step(0, 1, 1);
      check("both_ring", {31'b0, ringing}, 32'd0);
      check("both_snz", {31'b0, snooze_active}, 32'd0);

      en = 0;
      go(9, 58, 59);
      go(9, 59, 0);
      check("dis_match", {31'b0, ringing}, 32'd0);
      en = 1;
      step(0, 0, 0);
      check("en_late", {31'b0, ringing}, 32'd0);

      go(9, 58, 59);
      go(9, 59, 0);
      step(0, 1, 0);
      en = 0;
      step(0, 0, 0);
      check("dis_snz", {31'b0, snooze_active}, 32'd0);
      en = 1;
      go(10, 3, 59);
      go(10, 4, 0);
      check("dis_snz_hit", {31'b0, ringing}, 32'd0);

      go(9, 58, 59);
      go(9, 59, 0);
      sec(1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("reset_mid", outs(), 32'h0);
      model_reset();
      @(negedge clk) reset = 1'b1;
      now = 9 * 3600 + 59 * 60;
      step(0, 0, 0);
      check("rel_match", {31'b0, ringing}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
